pacman_ctrl_sequencer: RTL and testbench

Command scheduler between the SoC's 32-bit software control word and the Pac-Man game logic. It detects each new command written by the Nios (toggle-bit handshake) and buffers it in a small FIFO. It executes at most one command per game frame tick, sequencing the game state machine (IDLE/RUN/PAUSED) and Pac-Man's direction register. It also reports overflow and dropped-command statistics for debug.

---
 rtl/pacman_ctrl_sequencer_if.sv | 28 ++
 rtl/pacman_ctrl_sequencer.sv | 144 ++++++++++++++
 tb/tb_pacman_ctrl_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pacman_ctrl_sequencer_if.sv
// Command/status bundle between the SoC control word and the Pac-Man command sequencer.
// The signal names follow the Platform Designer export names used by the SoC.
interface pacman_ctrl_sequencer_if #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]      control_export;
   logic             tick;
   logic [1:0]       game_state;
   logic [1:0]       pac_dir;
   logic             dir_update;
   logic             game_reset;
   logic             overflow;
   logic [CNT_W-1:0] drop_count;
   logic [LVL_W-1:0] fifo_level;

   modport master (
      output control_export, tick,
      input  game_state, pac_dir, dir_update, game_reset, overflow, drop_count, fifo_level
   );

   modport slave (
      input  control_export, tick,
      output game_state, pac_dir, dir_update, game_reset, overflow, drop_count, fifo_level
   );
endinterface

// File: rtl/pacman_ctrl_sequencer.sv
// Captures toggle-handshake commands from the Nios into a FIFO.
// It executes at most one command per frame tick, driving the game state and Pac-Man direction.
module pacman_ctrl_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input logic                    clk_clk,
   input logic                    reset_reset_n,
   pacman_ctrl_sequencer_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MOVE  = 3'd1;
   localparam logic [2:0] OP_START = 3'd2;
   localparam logic [2:0] OP_PAUSE = 3'd3;
   localparam logic [2:0] OP_RESET = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_e;

   typedef struct packed {
      logic [2:0] opcode;
      logic [1:0] arg;
   } cmd_t;

   cmd_t             mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             prev_tog_q;
   state_e           state_q, state_d;
   logic [1:0]       pac_dir_q, pac_dir_d;
   logic             dir_update_q, dir_update_d;
   logic             game_reset_q, game_reset_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;
   logic [CNT_W:0]   drop_sum;

   cmd_t in_cmd, head;
   logic new_cmd, push_req, push, pop, full, ovf_drop, exec_drop, flush;
   logic unused_payload;

   assign unused_payload = ^bus.control_export[27:2];

   assign in_cmd   = {bus.control_export[30:28], bus.control_export[1:0]};
   assign new_cmd  = bus.control_export[31] ^ prev_tog_q;
   assign push_req = new_cmd && (in_cmd.opcode != OP_NOP);
   assign pop      = bus.tick && (level_q != '0);
   assign full     = (level_q == LVL_W'(FIFO_DEPTH));
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push     = push_req && (!full || pop);
   assign ovf_drop = push_req && !push;
   assign head     = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      state_d      = state_q;
      pac_dir_d    = pac_dir_q;
      dir_update_d = 1'b0;
      game_reset_d = 1'b0;
      exec_drop    = 1'b0;
      flush        = 1'b0;
      if (pop) begin
         case (head.opcode)
            OP_MOVE: begin
               if (state_q == ST_RUN) begin
                  pac_dir_d    = head.arg;
                  dir_update_d = 1'b1;
               end else begin
                  exec_drop = 1'b1;
               end
            end
            OP_START: state_d = ST_RUN;
            OP_PAUSE: if (state_q == ST_RUN) state_d = ST_PAUSED;
            OP_RESET: begin
               state_d      = ST_IDLE;
               pac_dir_d    = 2'd0;
               game_reset_d = 1'b1;
               flush        = 1'b1;
            end
            default: exec_drop = 1'b1;
         endcase
      end

      // A flush realigns the read pointer onto the slot written this cycle, so a same-cycle capture survives.
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         level_d  = LVL_W'(push);
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
      end

      overflow_d   = overflow_q | ovf_drop;
      drop_sum     = {1'b0, drop_count_q} + (CNT_W+1)'(ovf_drop) + (CNT_W+1)'(exec_drop);
      drop_count_d = (drop_sum > {1'b0, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
   end

   // NOTE: the storage array has no reset; level and pointers alone define which entries are valid.
   always_ff @(posedge clk_clk) begin
      if (push) mem_q[wr_ptr_q] <= in_cmd;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         prev_tog_q   <= 1'b0;
         state_q      <= ST_IDLE;
         pac_dir_q    <= 2'd0;
         dir_update_q <= 1'b0;
         game_reset_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         prev_tog_q   <= bus.control_export[31];
         state_q      <= state_d;
         pac_dir_q    <= pac_dir_d;
         dir_update_q <= dir_update_d;
         game_reset_q <= game_reset_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign bus.game_state = state_q;
   assign bus.pac_dir    = pac_dir_q;
   assign bus.dir_update = dir_update_q;
   assign bus.game_reset = game_reset_q;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_count_q;
   assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_pacman_ctrl_sequencer.sv
// Directed bench for pacman_ctrl_sequencer: a vector table of commands and ticks with hand-computed
// outputs, then hand-written sequences for mid-operation reset and drop-counter saturation.
module tb_pacman_ctrl_sequencer;
   localparam logic [2:0] NOP = 3'd0, MOVE = 3'd1, START = 3'd2, PAUSE = 3'd3, RESET = 3'd4;

   typedef struct {
      logic       wr;
      logic [2:0] op;
      logic [1:0] pl;
      logic       tk;
      logic [1:0] st;
      logic [1:0] dir;
      logic       du;
      logic       gr;
      logic [2:0] lvl;
      logic       ovf;
      logic [7:0] drop;
   } vec_t;

   logic clk;
   logic rst_n;
   logic tog;
   int   n_checks;
   int   n_fail;
   vec_t vecs[$];

   pacman_ctrl_sequencer_if #(.FIFO_DEPTH(4), .CNT_W(8)) bus_if ();

   pacman_ctrl_sequencer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .bus          (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write_word(input logic [2:0] op, input logic [1:0] pl);
      tog = ~tog;
      bus_if.control_export = {tog, op, 26'd0, pl};
   endtask

   function automatic vec_t v(input logic wr, input logic [2:0] op, input logic [1:0] pl,
                              input logic tk, input logic [1:0] st, input logic [1:0] dir,
                              input logic du, input logic gr, input logic [2:0] lvl,
                              input logic ovf, input logic [7:0] drop);
      vec_t r;
      r = '{wr, op, pl, tk, st, dir, du, gr, lvl, ovf, drop};
      return r;
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      tog      = 1'b0;
      rst_n    = 1'b0;
      bus_if.control_export = 32'd0;
      bus_if.tick = 1'b0;

      //         wr op     pl tk   st dir du gr lvl ovf drop
      vecs.push_back(v(1, START, 0, 0,  0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, MOVE,  3, 0,  1, 0, 0, 0, 1, 0, 0));
      vecs.push_back(v(1, MOVE,  2, 0,  1, 0, 0, 0, 2, 0, 0));
      vecs.push_back(v(0, NOP,   0, 1,  1, 3, 1, 0, 1, 0, 0));
      vecs.push_back(v(0, NOP,   0, 1,  1, 2, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, NOP,   0, 0,  1, 2, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, MOVE,  1, 0,  1, 2, 0, 0, 1, 0, 0));
      vecs.push_back(v(1, MOVE,  0, 0,  1, 2, 0, 0, 2, 0, 0));
      vecs.push_back(v(1, MOVE,  3, 0,  1, 2, 0, 0, 3, 0, 0));
      vecs.push_back(v(1, MOVE,  1, 0,  1, 2, 0, 0, 4, 0, 0));
      vecs.push_back(v(1, MOVE,  2, 0,  1, 2, 0, 0, 4, 1, 1));
      vecs.push_back(v(1, MOVE,  2, 0,  1, 2, 0, 0, 4, 1, 2));
      vecs.push_back(v(1, PAUSE, 0, 1,  1, 1, 1, 0, 4, 1, 2));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 1, 0, 3, 1, 2));
      vecs.push_back(v(0, NOP,   0, 1,  1, 3, 1, 0, 2, 1, 2));
      vecs.push_back(v(0, NOP,   0, 1,  1, 1, 1, 0, 1, 1, 2));
      vecs.push_back(v(0, NOP,   0, 1,  2, 1, 0, 0, 0, 1, 2));
      vecs.push_back(v(1, RESET, 0, 0,  2, 1, 0, 0, 1, 1, 2));
      vecs.push_back(v(0, NOP,   0, 1,  0, 0, 0, 1, 0, 1, 2));
      vecs.push_back(v(0, NOP,   0, 0,  0, 0, 0, 0, 0, 1, 2));
      vecs.push_back(v(1, MOVE,  2, 0,  0, 0, 0, 0, 1, 1, 2));
      vecs.push_back(v(0, NOP,   0, 1,  0, 0, 0, 0, 0, 1, 3));
      vecs.push_back(v(1, PAUSE, 0, 0,  0, 0, 0, 0, 1, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  0, 0, 0, 0, 0, 1, 3));
      vecs.push_back(v(1, START, 0, 0,  0, 0, 0, 0, 1, 1, 3));
      vecs.push_back(v(1, MOVE,  1, 0,  0, 0, 0, 0, 2, 1, 3));
      vecs.push_back(v(1, PAUSE, 0, 0,  0, 0, 0, 0, 3, 1, 3));
      vecs.push_back(v(1, RESET, 0, 0,  0, 0, 0, 0, 4, 1, 3));
      vecs.push_back(v(1, MOVE,  3, 1,  1, 0, 0, 0, 4, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  1, 1, 1, 0, 3, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  2, 1, 0, 0, 2, 1, 3));
      vecs.push_back(v(1, START, 0, 1,  0, 0, 0, 1, 1, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 0, 0, 0, 1, 3));
      vecs.push_back(v(1, PAUSE, 0, 0,  1, 0, 0, 0, 1, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  2, 0, 0, 0, 0, 1, 3));
      vecs.push_back(v(1, START, 0, 0,  2, 0, 0, 0, 1, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 0, 0, 0, 1, 3));
      vecs.push_back(v(1, START, 0, 1,  1, 0, 0, 0, 1, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 0, 0, 0, 1, 3));
      vecs.push_back(v(1, NOP,   0, 0,  1, 0, 0, 0, 0, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 0, 0, 0, 1, 3));
      vecs.push_back(v(1, 3'd6,  1, 1,  1, 0, 0, 0, 1, 1, 3));
      vecs.push_back(v(0, NOP,   0, 1,  1, 0, 0, 0, 0, 1, 4));

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_state", 32'(bus_if.game_state), 32'd0);
      check("rst_dir",   32'(bus_if.pac_dir),    32'd0);
      check("rst_du",    32'(bus_if.dir_update), 32'd0);
      check("rst_gr",    32'(bus_if.game_reset), 32'd0);
      check("rst_ovf",   32'(bus_if.overflow),   32'd0);
      check("rst_drop",  32'(bus_if.drop_count), 32'd0);
      check("rst_lvl",   32'(bus_if.fifo_level), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].wr) write_word(vecs[i].op, vecs[i].pl);
         bus_if.tick = vecs[i].tk;
         cycle();
         check($sformatf("row%0d_state", i), 32'(bus_if.game_state), 32'(vecs[i].st));
         check($sformatf("row%0d_dir",   i), 32'(bus_if.pac_dir),    32'(vecs[i].dir));
         check($sformatf("row%0d_du",    i), 32'(bus_if.dir_update), 32'(vecs[i].du));
         check($sformatf("row%0d_gr",    i), 32'(bus_if.game_reset), 32'(vecs[i].gr));
         check($sformatf("row%0d_lvl",   i), 32'(bus_if.fifo_level), 32'(vecs[i].lvl));
         check($sformatf("row%0d_ovf",   i), 32'(bus_if.overflow),   32'(vecs[i].ovf));
         check($sformatf("row%0d_drop",  i), 32'(bus_if.drop_count), 32'(vecs[i].drop));
      end
      bus_if.tick = 1'b0;

      // Asynchronous reset with a queued command; a word with bit 31 = 1 at release is captured at once
      write_word(MOVE, 2'd2);
      cycle();
      check("mid_lvl_before", 32'(bus_if.fifo_level), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_lvl_async",   32'(bus_if.fifo_level), 32'd0);
      check("mid_state_async", 32'(bus_if.game_state), 32'd0);
      check("mid_ovf_async",   32'(bus_if.overflow),   32'd0);
      check("mid_drop_async",  32'(bus_if.drop_count), 32'd0);
      @(negedge clk);
      tog = 1'b1;
      bus_if.control_export = {1'b1, START, 28'd0};
      rst_n = 1'b1;
      cycle();
      check("rel_capture_lvl", 32'(bus_if.fifo_level), 32'd1);
      cycle();
      check("rel_static_lvl", 32'(bus_if.fifo_level), 32'd1);
      bus_if.tick = 1'b1;
      cycle();
      bus_if.tick = 1'b0;
      check("rel_start_state", 32'(bus_if.game_state), 32'd1);
      check("rel_start_lvl",   32'(bus_if.fifo_level), 32'd0);

      // Reserved opcode drops saturate the counter without touching overflow
      rst_n = 1'b0;
      tog = 1'b0;
      bus_if.control_export = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         write_word(3'd7, 2'd0);
         cycle();
         bus_if.tick = 1'b1;
         cycle();
         bus_if.tick = 1'b0;
         if (i == 9)   check("sat_drop_10",  32'(bus_if.drop_count), 32'd10);
         if (i == 253) check("sat_drop_254", 32'(bus_if.drop_count), 32'd254);
      end
      check("sat_drop_final", 32'(bus_if.drop_count), 32'd255);
      check("sat_ovf",        32'(bus_if.overflow),   32'd0);
      check("sat_lvl",        32'(bus_if.fifo_level), 32'd0);
      check("sat_state",      32'(bus_if.game_state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
